// File: rtl/reg_writeback_pkg.sv
// Shared core constants for the writeback path plus the result-source encoding.
package reg_writeback_pkg;
  localparam int XLEN       = 32;
  localparam int REG_AWIDTH = 5;
  localparam int REG_CNT    = 1 << REG_AWIDTH;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;
endpackage

// File: rtl/reg_writeback_if.sv
// Issue, result and register-file write signals between decode, execute units and writeback.
interface reg_writeback_if
  import reg_writeback_pkg::*;
#(
  parameter int DWIDTH = XLEN
);
  logic                  iss_valid;
  logic [REG_AWIDTH-1:0] iss_rd;
  logic                  iss_ready;
  logic                  a_valid;
  logic                  a_ready;
  logic [REG_AWIDTH-1:0] a_rd;
  logic [DWIDTH-1:0]     a_data;
  logic                  b_valid;
  logic                  b_ready;
  logic [REG_AWIDTH-1:0] b_rd;
  logic [DWIDTH-1:0]     b_data;
  logic                  wb_wr;
  logic [REG_AWIDTH-1:0] wb_addr;
  logic [DWIDTH-1:0]     wb_data;
  logic [REG_AWIDTH-1:0] chk_rs1;
  logic [REG_AWIDTH-1:0] chk_rs2;
  logic                  busy_rs1;
  logic                  busy_rs2;
  logic                  idle;
  logic                  err_unres;

  modport slave (
    input  iss_valid, iss_rd, a_valid, a_rd, a_data, b_valid, b_rd, b_data, chk_rs1, chk_rs2,
    output iss_ready, a_ready, b_ready, wb_wr, wb_addr, wb_data, busy_rs1, busy_rs2, idle, err_unres
  );

  modport master (
    output iss_valid, iss_rd, a_valid, a_rd, a_data, b_valid, b_rd, b_data, chk_rs1, chk_rs2,
    input  iss_ready, a_ready, b_ready, wb_wr, wb_addr, wb_data, busy_rs1, busy_rs2, idle, err_unres
  );
endinterface

// File: rtl/reg_writeback_wb_arb2.sv
// Two-input round-robin arbiter; gnt[0] is source A, gnt[1] is source B.
module wb_arb2
  import reg_writeback_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  src_e last_grant;

  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      if (req == 2'b11) gnt = (last_grant == SRC_A) ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

  // Reset to "A last" so B wins the first contested cycle.
  always_ff @(posedge clk) begin
    if (rst)         last_grant <= SRC_A;
    else if (gnt[1]) last_grant <= SRC_B;
    else if (gnt[0]) last_grant <= SRC_A;
  end
endmodule

// File: rtl/reg_writeback.sv
// Writeback stage: arbitrates ALU/load results onto the register-file write port and tracks pending destinations.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int DWIDTH = XLEN
)(
  input logic           clk,
  input logic           rst,
  reg_writeback_if.slave bus
);
  localparam int AWIDTH = REG_AWIDTH;

  logic [1:0]          gnt;
  logic                xfer;
  logic [AWIDTH-1:0]   xfer_rd;
  logic [DWIDTH-1:0]   xfer_data;
  logic                xfer_wr;
  logic                iss_fire;
  logic [REG_CNT-1:1]  pend_q;
  logic [REG_CNT-1:1]  pend_nxt;
  logic [REG_CNT-1:0]  pending;
  logic                wr_q;
  logic [AWIDTH-1:0]   addr_q;
  logic [DWIDTH-1:0]   data_q;
  logic                err_q;

  wb_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({bus.b_valid, bus.a_valid}),
    .gnt (gnt)
  );

  assign pending   = {pend_q, 1'b0};
  assign xfer      = |gnt;
  assign xfer_rd   = gnt[1] ? bus.b_rd   : bus.a_rd;
  assign xfer_data = gnt[1] ? bus.b_data : bus.a_data;
  assign xfer_wr   = xfer && (xfer_rd != '0);

  assign bus.a_ready   = gnt[0];
  assign bus.b_ready   = gnt[1];
  assign bus.iss_ready = !rst && !pending[bus.iss_rd];
  assign iss_fire      = bus.iss_valid && bus.iss_ready && (bus.iss_rd != '0);

  // Issue set is applied after the transfer clear so a same-edge re-reservation survives.
  always_comb begin
    pend_nxt = pend_q;
    for (int i = 1; i < REG_CNT; i++) begin
      if (xfer_wr && xfer_rd == AWIDTH'(i))      pend_nxt[i] = 1'b0;
      if (iss_fire && bus.iss_rd == AWIDTH'(i))  pend_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_nxt;
      wr_q   <= xfer_wr;
      if (xfer_wr) begin
        addr_q <= xfer_rd;
        data_q <= xfer_data;
        if (!pending[xfer_rd]) err_q <= 1'b1;
      end
    end
  end

  assign bus.wb_wr     = wr_q;
  assign bus.wb_addr   = addr_q;
  assign bus.wb_data   = data_q;
  assign bus.err_unres = err_q;

  // Stay busy through the write cycle: the regfile only captures data at the end of it.
  assign bus.busy_rs1 = pending[bus.chk_rs1] || (wr_q && addr_q == bus.chk_rs1);
  assign bus.busy_rs2 = pending[bus.chk_rs2] || (wr_q && addr_q == bus.chk_rs2);
  assign bus.idle     = (pend_q == '0) && !wr_q;
endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 Parameter DWIDTH, default XLEN, write-data width; localparam AWIDTH = REG_AWIDTH; register count REG_CNT from shared package.
REQ-002 The block SHALL have one clock and a reset that is synchronous and active-high, with the ports listed below.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous reset, active-high.
REQ-005 iss_valid  in  1  decode issues an instruction that writes iss_rd.
REQ-006 iss_rd  in  AWIDTH  destination register being reserved.
REQ-007 iss_ready  out  1  issue accepted this cycle (combinational).
REQ-008 a_valid / a_ready  in / out  1  ALU result handshake.
REQ-009 a_rd, a_data  in  AWIDTH, DWIDTH  ALU result destination and value.
REQ-010 b_valid / b_ready  in / out  1  load-unit result handshake.
REQ-011 b_rd, b_data  in  AWIDTH, DWIDTH  load result destination and value.
REQ-012 wb_wr, wb_addr, wb_data  out  1, AWIDTH, DWIDTH  register-file write port (Wr, WAddr, Din), registered.
REQ-013 chk_rs1, chk_rs2  in  AWIDTH  decode source-register queries.
REQ-014 busy_rs1, busy_rs2  out  1  queried register has a write pending (combinational).
REQ-015 idle  out  1  no register pending and no write in flight.
REQ-016 err_unres  out  1  sticky: result accepted for a non-pending nonzero rd.

Function
REQ-017 Transfer on a source occurs when valid and ready are both 1 at a rising edge; at most one source transfers per cycle.
REQ-018 Both valid: round-robin grant; a 1-bit last_grant register flips to the granted source; after reset B has priority.
REQ-019 Only one valid: that source is granted regardless of last_grant, and last_grant is updated.
REQ-020 Granted ready is 1, other ready 0; no dependency of ready on the output register (write port never stalls).
REQ-021 Cycle after transfer: wb_wr=1, wb_addr=rd, wb_data=data; otherwise wb_wr=0, wb_addr/wb_data hold last values.
REQ-022 rd=0 transfer: accepted, wb_wr stays 0, no scoreboard change.
REQ-023 Scoreboard: pending[REG_CNT-1:1]; pending[0] constant 0.
REQ-024 Issue accepted (iss_valid & iss_ready, iss_rd!=0) sets pending[iss_rd] at the edge.
REQ-025 iss_ready = !pending[iss_rd] (WAW stall); iss_rd=0 always ready.
REQ-026 A transfer to rd clears pending[rd] at the same edge the write is registered.
REQ-027 Same-edge issue and transfer to one rd: impossible under REQ-025 since issue requires not pending; if rd not pending, transfer still writes, err_unres sets, issue set takes effect.
REQ-028 busy_rsN = pending[chk_rsN] | (transfer this cycle to chk_rsN is NOT counted) -- i.e. busy clears the cycle after transfer, same cycle wb_wr asserts; decode forwards nothing.
REQ-029 Read-after-write into regmem: regmem writes on the edge ending the wb_wr cycle, so busy clear one cycle earlier than data visible is forbidden; busy_rsN SHALL also be 1 when wb_wr=1 and wb_addr=chk_rsN.
REQ-030 idle = (pending==0) & !wb_wr.

Reset
REQ-031 rst at a rising edge: pending=0, wb_wr=0, wb_addr=0, wb_data=0, last_grant selects B next, err_unres=0.
REQ-032 During rst cycle a_ready=b_ready=0 and iss_ready=0; in-flight handshakes are dropped.
REQ-033 Reset mid-operation discards pending writes; no wb_wr pulse follows reset.

Structure
REQ-034 XLEN, REG_AWIDTH, REG_CNT stay in the shared core package; a source enum (SRC_A, SRC_B) is added there.
REQ-035 Arbitration lives in sub-module wb_arb2 (2-input round-robin, grant vector out, last_grant inside).
REQ-036 Scoreboard, output register and error flag live in reg_writeback.

Verification
REQ-037 Reset, issue rd=5, A returns rd=5 data 0xDEADBEEF -> next cycle wb_wr=1, wb_addr=5, wb_data=0xDEADBEEF; busy for 5 clears after that cycle.
REQ-038 A and B valid together three cycles (rd 3/4) -> grants B,A,B; one wb_wr per cycle; stalled source holds data.
REQ-039 Issue rd=7 twice back to back -> second iss_ready=0 until rd 7 written.
REQ-040 B returns rd=0 data 0x1234 -> b_ready=1, wb_wr stays 0, err_unres stays 0.
REQ-041 A returns rd=9 with no issue -> write occurs, err_unres=1 until rst.
REQ-042 Issue rd 2,3, assert rst before results -> pending cleared, idle=1, no wb_wr pulse.
